// File: rtl/uart_sm_rx_pkg.sv
// Shared UART definitions: receiver state encoding, default bit period and
// frame constants. The transmitter imports the same package so both ends
// agree on the bit period and frame shape.
package uart_sm_rx_pkg;

  // Default clocks per serial bit, common to transmitter and receiver.
  localparam int unsigned CYCLES_PER_BIT_DEF = 32;

  // Frame shape: 8 data bits LSB first, one stop bit at logic 1.
  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sm_rx_if.sv
// Receiver-side signal bundle.
//   rx         : serial line into the receiver (idle high, asynchronous)
//   byte_out   : last correctly framed byte
//   byte_valid : one-cycle strobe, byte_out just updated
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : receiver is not in IDLE
// master = the receiver, slave = the line driver / byte consumer.
interface uart_sm_rx_if;
  import uart_sm_rx_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] byte_out;
  logic                 byte_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output byte_out, byte_valid, frame_err, busy);
  modport slave  (output rx, input byte_out, byte_valid, frame_err, busy);
endinterface

// File: rtl/uart_sm_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   reset : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (two clocks of latency)
// RESET_VAL sets the value both flops take in reset.
module uart_sm_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_sm_rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 stop, no parity.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : uart_sm_rx_if.master (rx in; byte_out, byte_valid, frame_err,
//           busy out, all registered)
// The start bit is re-checked half a bit after the falling edge, then every
// data and stop bit is sampled one full bit period later, i.e. at its centre.
module uart_sm_rx
  import uart_sm_rx_pkg::*;
#(
  parameter int unsigned CYCLES_PER_BIT = CYCLES_PER_BIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  uart_sm_rx_if.master  bus
);

  localparam int unsigned HALF_BIT = CYCLES_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CYCLES_PER_BIT);
  localparam int unsigned IDX_W    = 3;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] byte_q, byte_nxt;
  logic                 valid_q, valid_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 busy_q;
  logic                 rx_s;

  // Bring the asynchronous line into the clk domain; idles high in reset.
  uart_sm_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      byte_q  <= byte_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      // Registered from the next state so busy tracks state exactly.
      busy_q  <= (state_nxt != IDLE);
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    byte_nxt    = byte_q;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        count_nxt = '0;
        if (!rx_s) state_nxt = START;
      end

      START: begin
        if (count == CNT_HALF_LAST) begin
          count_nxt = '0;
          if (!rx_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      DATA: begin
        if (count == CNT_BIT_LAST) begin
          count_nxt = '0;
          shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) state_nxt = STOP;
          else                     bit_idx_nxt = bit_idx + IDX_W'(1);
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      STOP: begin
        if (count == CNT_BIT_LAST) begin
          count_nxt = '0;
          if (rx_s == STOP_LEVEL) begin
            byte_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BRK_WAIT;
          end
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      // Hold off until a held-low (break) line returns high.
      BRK_WAIT: begin
        count_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;

endmodule
